// File: rtl/alu_16bit.sv
// 16-bit add/subtract ALU with carry-in and registered NZVC status flags.
// A B/Cin inversion stage feeds a ripple of 16 full-adder slices; the
// sum and the flags derived from it are captured in one output register.
// There is no handshake: a new operation is accepted on every rising edge
// and its result is visible one cycle later.
module alu_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Op,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Z,
  output logic        N,
  output logic        V,
  output logic        C
);

  // Operand conditioning: subtract is A + ~B + ~Cin, so a borrow-in of 1
  // becomes a carry-in of 0 and the carry-out reads as "no borrow".
  logic [15:0] b_cond;
  logic        c_cond;

  // Carry chain and per-slice sum bits of the ripple adder.
  logic [16:0] carry;
  logic [15:0] sum;

  // Next-state values for the output register.
  logic [15:0] s_next;
  logic        z_next;
  logic        n_next;
  logic        v_next;
  logic        c_next;

  // Invert B and the carry-in when subtracting.
  always_comb begin
    b_cond = B ^ {16{Op}};
    c_cond = Cin ^ Op;
  end

  // Ripple of 16 full-adder slices, LSB first; carry[16] is the carry-out.
  always_comb begin
    carry    = 17'd0;
    sum      = 16'd0;
    carry[0] = c_cond;
    for (int i = 0; i < 16; i++) begin
      sum[i]     = A[i] ^ b_cond[i] ^ carry[i];
      carry[i+1] = (A[i] & b_cond[i]) | (A[i] & carry[i]) | (b_cond[i] & carry[i]);
    end
  end

  // Status flags from the combinational result. Overflow means the
  // operands (as seen by the signed operation) agree in sign while the
  // result's sign differs from A.
  always_comb begin
    s_next = sum;
    z_next = (sum == 16'h0000);
    n_next = sum[15];
    c_next = carry[16];
    if (Op) begin
      v_next = (A[15] ^ B[15]) & (A[15] ^ sum[15]);
    end else begin
      v_next = ~(A[15] ^ B[15]) & (A[15] ^ sum[15]);
    end
  end

  // Result/flag register; synchronous reset has priority over any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      S <= 16'h0000;
      Z <= 1'b0;
      N <= 1'b0;
      V <= 1'b0;
      C <= 1'b0;
    end else begin
      S <= s_next;
      Z <= z_next;
      N <= n_next;
      V <= v_next;
      C <= c_next;
    end
  end

endmodule

// File: tb/tb_alu_16bit.sv
// Self-checking bench for alu_16bit: reset, a table of hand-computed
// directed vectors, a back-to-back pipelined sequence, input changes
// between edges, reset priority, and random vectors against a 17-bit model.
module tb_alu_16bit;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        Op;
  logic        Cin;
  logic [15:0] S;
  logic        Z;
  logic        N;
  logic        V;
  logic        C;

  int total_checks;
  int passed_checks;

  // Packed {S, Z, N, V, C} expectations for the pipelined sequences.
  logic [19:0] exp_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic        cin;
    logic [15:0] exp_s;
    logic        exp_z;
    logic        exp_n;
    logic        exp_v;
    logic        exp_c;
  } vec_t;

  vec_t vecs[14];

  alu_16bit dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .Op  (Op),
    .Cin (Cin),
    .S   (S),
    .Z   (Z),
    .N   (N),
    .V   (V),
    .C   (C)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: add uses a plain 17-bit sum, subtract decides the
  // carry by an exact unsigned comparison rather than by the adder trick.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic op, input logic cin);
    logic [16:0] wide;
    logic [15:0] s;
    logic        c;
    logic        v;
    if (!op) begin
      wide = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      s    = wide[15:0];
      c    = wide[16];
      v    = (a[15] == b[15]) && (s[15] != a[15]);
    end else begin
      s    = a - b - {15'd0, cin};
      c    = ({1'b0, a} >= ({1'b0, b} + {16'd0, cin}));
      v    = (a[15] != b[15]) && (s[15] != a[15]);
    end
    return {s, (s == 16'h0000), s[15], v, c};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    total_checks++;
    if (act === exp) begin
      passed_checks++;
    end else begin
      $display("FAIL %s: got S=%h ZNVC=%b, expected S=%h ZNVC=%b",
               name, act[19:4], act[3:0], exp[19:4], exp[3:0]);
    end
  endtask

  // Driver: present one operation (called just after an active edge).
  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic op, input logic cin);
    A   = a;
    B   = b;
    Op  = op;
    Cin = cin;
  endtask

  function automatic logic [19:0] outs();
    return {S, Z, N, V, C};
  endfunction

  initial begin
    logic [19:0] exp;
    logic [19:0] held;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rop;
    logic        rcin;

    total_checks  = 0;
    passed_checks = 0;

    //               a        b        op    cin   s        z     n     v     c
    vecs[0]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFE, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{16'h5555, 16'hAAAA, 1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{16'h1234, 16'hFFFF, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset with arbitrary inputs present.
    rst = 1'b1;
    drive(16'hDEAD, 16'hBEEF, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("reset", outs(), 20'h0_0000);
    rst = 1'b0;

    // Directed table.
    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].exp_s, vecs[i].exp_z, vecs[i].exp_n, vecs[i].exp_v, vecs[i].exp_c});
    end

    // Inputs changing between edges must not disturb the registered result.
    held = outs();
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    #2;
    check("hold_between_edges", outs(), held);
    @(posedge clk);
    #1;
    check("after_hold_edge", outs(), {16'h8000, 1'b0, 1'b1, 1'b1, 1'b0});

    // Reset wins over an operation in the same cycle.
    rst = 1'b1;
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("reset_priority", outs(), 20'h0_0000);
    rst = 1'b0;

    // Back-to-back add then sub, each result exactly one cycle later.
    drive(16'h1000, 16'h0234, 1'b0, 1'b1);
    exp_q.push_back({16'h1235, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check("b2b_add", outs(), exp);
    drive(16'h1000, 16'h0234, 1'b1, 1'b1);
    exp_q.push_back({16'h0DCB, 1'b0, 1'b0, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check("b2b_sub", outs(), exp);

    // Random add/sub stream on consecutive edges against the model.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 16'hFFFF;
        1:       ra = 16'h8000;
        default: ra = 16'($urandom_range(0, 65535));
      endcase
      case ($urandom_range(0, 3))
        0:       rb = 16'hFFFF;
        1:       rb = ra;
        default: rb = 16'($urandom_range(0, 65535));
      endcase
      rop  = 1'($urandom_range(0, 1));
      rcin = 1'($urandom_range(0, 1));
      drive(ra, rb, rop, rcin);
      exp_q.push_back(model(ra, rb, rop, rcin));
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      check($sformatf("rand%0d_%s_%h_%h_%0d", i, rop ? "sub" : "add", ra, rb, rcin),
            outs(), exp);
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
